// File: rtl/face_swap_pkg.sv
// Shared definitions for the face_swap video path.
// Contents:
//   FS_DATA_WIDTH / FS_DIM_BITS / FS_CNT_BITS  default pixel, dimension and counter widths
//   fr_state_e                                 framer state encoding
//   fs_beat_t                                  one stream beat {tdata, tlast, tuser}
package face_swap_pkg;

  localparam int FS_DATA_WIDTH = 32;
  localparam int FS_DIM_BITS   = 12;
  localparam int FS_CNT_BITS   = 16;

  typedef enum logic [0:0] {
    FR_IDLE = 1'b0,
    FR_RUN  = 1'b1
  } fr_state_e;

  typedef struct packed {
    logic [FS_DATA_WIDTH-1:0] tdata;
    logic                     tlast;
    logic                     tuser;
  } fs_beat_t;

endpackage

// File: rtl/axis_video_framer_if.sv
// AXI4-Stream video bundle used on both sides of the framer.
// Signals: tdata (pixel), tvalid, tready, tlast (end-of-line), tuser (start-of-frame).
// Modports: master drives data/valid/last/user and samples ready; slave is the mirror.
interface axis_video_framer_if
  import face_swap_pkg::*;
#(
  parameter int DATA_WIDTH = FS_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer for a valid/ready stream of WIDTH-bit beats.
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   s_data_i/s_valid_i     upstream beat and valid
//   s_ready_o              upstream ready, driven straight from a flop (no path from m_ready_i)
//   m_data_o/m_valid_o     registered downstream beat and valid
//   m_ready_i              downstream ready
// The output register is the main entry; the skid entry catches the beat that was
// accepted while the output was stalled, so ready can be registered without losing data.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_hs_s;

  assign s_ready_o = ~skid_valid_q;
  assign m_data_o  = out_data_q;
  assign m_valid_o = out_valid_q;
  assign in_hs_s   = s_valid_i & ~skid_valid_q;

  // Next-state: refill the output register from skid first, else from the input.
  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || m_ready_i) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_hs_s) begin
        out_data_d  = s_data_i;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      if (in_hs_s) begin
        skid_data_d  = s_data_i;
        skid_valid_d = 1'b1;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
  end

  // Storage registers; reset drops any buffered beat without a handshake.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_data_q   <= {WIDTH{1'b0}};
      out_valid_q  <= 1'b0;
      skid_data_q  <= {WIDTH{1'b0}};
      skid_valid_q <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
    end
  end

endmodule

// File: rtl/axis_video_framer.sv
// Regenerates AXI4-Stream video framing (tuser = start-of-frame, tlast = end-of-line)
// from latched line width/height, flags upstream tlast mismatches, counts frames.
// Ports:
//   ACLK, ARESETN            clock, synchronous active-low reset
//   cfg_enable/width/height  framer configuration, sampled at frame boundaries only
//   stat_clear               pulse clearing sticky errors and the frame counter
//   s_axis (slave)           input pixels; tlast is only checked, tuser ignored
//   m_axis (master)          framed output pixels through a 2-entry skid buffer
//   stat_busy                frame in progress (first accept .. last output beat)
//   stat_err_early/late      sticky upstream tlast mismatch flags
//   stat_frames              completed-frame count
module axis_video_framer
  import face_swap_pkg::*;
#(
  parameter int DATA_WIDTH = FS_DATA_WIDTH,
  parameter int DIM_BITS   = FS_DIM_BITS,
  parameter int CNT_BITS   = FS_CNT_BITS
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 cfg_enable,
  input  logic [DIM_BITS-1:0]  cfg_width,
  input  logic [DIM_BITS-1:0]  cfg_height,
  input  logic                 stat_clear,
  axis_video_framer_if.slave   s_axis,
  axis_video_framer_if.master  m_axis,
  output logic                 stat_busy,
  output logic                 stat_err_early,
  output logic                 stat_err_late,
  output logic [CNT_BITS-1:0]  stat_frames
);

  // Beat carried through the skid buffer: {tdata, tlast, tuser, eof}.
  // eof marks the last beat of the frame so the counter can fire on its output handshake.
  localparam int BEAT_W = DATA_WIDTH + 3;

  fr_state_e             state_q, state_d;
  logic [DIM_BITS-1:0]   px_q, px_d, ln_q, ln_d;
  logic [DIM_BITS-1:0]   wm1_q, wm1_d, hm1_q, hm1_d;
  logic                  err_early_q, err_early_d, err_late_q, err_late_d;
  logic                  busy_q, busy_d;
  logic [CNT_BITS-1:0]   frames_q, frames_d, frames_base_s;
  logic                  cfg_ok_s, in_hs_s, out_hs_s, px_last_s, ln_last_s;
  logic                  skid_ready_s, out_valid_s, eof_done_s;
  logic [BEAT_W-1:0]     in_beat_s, out_beat_s;
  logic                  unused_s;

  assign unused_s  = s_axis.tuser;
  assign cfg_ok_s  = cfg_enable && (cfg_width != {DIM_BITS{1'b0}}) && (cfg_height != {DIM_BITS{1'b0}});
  assign px_last_s = (px_q == wm1_q);
  assign ln_last_s = (ln_q == hm1_q);

  // Ready only depends on flops: state and skid occupancy.
  assign s_axis.tready = (state_q == FR_RUN) && skid_ready_s;
  assign in_hs_s       = s_axis.tvalid && s_axis.tready;
  assign in_beat_s     = {s_axis.tdata, px_last_s,
                          (px_q == {DIM_BITS{1'b0}}) && (ln_q == {DIM_BITS{1'b0}}),
                          px_last_s && ln_last_s};

  axis_skid_buffer #(.WIDTH(BEAT_W)) u_skid (
    .clk_i     (ACLK),
    .rst_ni    (ARESETN),
    .s_data_i  (in_beat_s),
    .s_valid_i (in_hs_s),
    .s_ready_o (skid_ready_s),
    .m_data_o  (out_beat_s),
    .m_valid_o (out_valid_s),
    .m_ready_i (m_axis.tready)
  );

  assign m_axis.tdata  = out_beat_s[BEAT_W-1:3];
  assign m_axis.tlast  = out_beat_s[2];
  assign m_axis.tuser  = out_beat_s[1];
  assign m_axis.tvalid = out_valid_s;
  assign out_hs_s      = out_valid_s && m_axis.tready;
  assign eof_done_s    = out_hs_s && out_beat_s[0];

  assign stat_busy      = busy_q;
  assign stat_err_early = err_early_q;
  assign stat_err_late  = err_late_q;
  assign stat_frames    = frames_q;

  // Next-state: FSM, pixel/line counters, sticky status; events override stat_clear.
  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    ln_d    = ln_q;
    wm1_d   = wm1_q;
    hm1_d   = hm1_q;
    case (state_q)
      FR_IDLE: begin
        if (cfg_ok_s) begin
          state_d = FR_RUN;
          wm1_d   = cfg_width - DIM_BITS'(1);
          hm1_d   = cfg_height - DIM_BITS'(1);
          px_d    = {DIM_BITS{1'b0}};
          ln_d    = {DIM_BITS{1'b0}};
        end else begin
          state_d = FR_IDLE;
        end
      end
      FR_RUN: begin
        if (in_hs_s) begin
          if (px_last_s) begin
            px_d = {DIM_BITS{1'b0}};
            if (ln_last_s) begin
              ln_d = {DIM_BITS{1'b0}};
              // Frame boundary: pick up new geometry or stop.
              if (cfg_ok_s) begin
                wm1_d = cfg_width - DIM_BITS'(1);
                hm1_d = cfg_height - DIM_BITS'(1);
              end else begin
                state_d = FR_IDLE;
              end
            end else begin
              ln_d = ln_q + DIM_BITS'(1);
            end
          end else begin
            px_d = px_q + DIM_BITS'(1);
          end
        end else begin
          state_d = FR_RUN;
        end
      end
      default: state_d = FR_IDLE;
    endcase

    err_early_d = (err_early_q && !stat_clear) || (in_hs_s && s_axis.tlast && !px_last_s);
    err_late_d  = (err_late_q && !stat_clear) || (in_hs_s && !s_axis.tlast && px_last_s);

    frames_base_s = stat_clear ? {CNT_BITS{1'b0}} : frames_q;
    if (eof_done_s) begin
      frames_d = frames_base_s + CNT_BITS'(1);
    end else begin
      frames_d = frames_base_s;
    end

    busy_d = (busy_q && !eof_done_s) || in_hs_s;
  end

  // State and status registers.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q     <= FR_IDLE;
      px_q        <= {DIM_BITS{1'b0}};
      ln_q        <= {DIM_BITS{1'b0}};
      wm1_q       <= {DIM_BITS{1'b0}};
      hm1_q       <= {DIM_BITS{1'b0}};
      err_early_q <= 1'b0;
      err_late_q  <= 1'b0;
      busy_q      <= 1'b0;
      frames_q    <= {CNT_BITS{1'b0}};
    end else begin
      state_q     <= state_d;
      px_q        <= px_d;
      ln_q        <= ln_d;
      wm1_q       <= wm1_d;
      hm1_q       <= hm1_d;
      err_early_q <= err_early_d;
      err_late_q  <= err_late_d;
      busy_q      <= busy_d;
      frames_q    <= frames_d;
    end
  end

endmodule

// File: tb/tb_axis_video_framer.sv
// Directed bench for axis_video_framer: frames are driven cycle by cycle, output beats
// are collected, and each scenario task compares against hand-computed values.
module tb_axis_video_framer;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        cfg_enable;
  logic [11:0] cfg_width;
  logic [11:0] cfg_height;
  logic        stat_clear;
  logic        stat_busy;
  logic        stat_err_early;
  logic        stat_err_late;
  logic [15:0] stat_frames;

  axis_video_framer_if #(.DATA_WIDTH(32)) s_if ();
  axis_video_framer_if #(.DATA_WIDTH(32)) m_if ();

  axis_video_framer #(.DATA_WIDTH(32), .DIM_BITS(12), .CNT_BITS(16)) dut (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .cfg_enable     (cfg_enable),
    .cfg_width      (cfg_width),
    .cfg_height     (cfg_height),
    .stat_clear     (stat_clear),
    .s_axis         (s_if),
    .m_axis         (m_if),
    .stat_busy      (stat_busy),
    .stat_err_early (stat_err_early),
    .stat_err_late  (stat_err_late),
    .stat_frames    (stat_frames)
  );

  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;
  logic [31:0] got_d[$];
  logic        got_l[$];
  logic        got_u[$];
  int first_in, first_out, stall_viol, timed_out;

  // Drives n pixels (data base+i, upstream tlast from mask bit i) and collects output beats.
  // rmode 0: downstream always ready; rmode 1: ready pattern 1,0,0,1.
  // drop_at: drop cfg_enable on the edge accepting that pixel (0 = never).
  // clr_last: pulse stat_clear on the edge of the final output handshake.
  task automatic drive_frame(input int n, input logic [31:0] base, input logic [15:0] mask,
                             input int rmode, input int drop_at, input bit clr_last);
    int cyc;
    int acc;
    bit prev_stall;
    logic [31:0] pd;
    logic pl, pu;
    got_d.delete(); got_l.delete(); got_u.delete();
    first_in = -1; first_out = -1; stall_viol = 0; timed_out = 0;
    cyc = 0; acc = 0; prev_stall = 1'b0; pd = 32'h0; pl = 1'b0; pu = 1'b0;
    while ((acc < n || got_d.size() < n) && cyc < 200) begin
      stat_clear  = 1'b0;
      s_if.tvalid = (acc < n);
      s_if.tdata  = base + 32'(acc);
      s_if.tlast  = (acc < n) ? mask[acc] : 1'b0;
      m_if.tready = (rmode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      if (prev_stall && (m_if.tvalid !== 1'b1 || m_if.tdata !== pd ||
                         m_if.tlast !== pl || m_if.tuser !== pu))
        stall_viol++;
      if (s_if.tvalid && s_if.tready) begin
        if (first_in < 0) first_in = cyc;
        acc++;
        if (acc == drop_at) cfg_enable = 1'b0;
      end
      if (m_if.tvalid && m_if.tready) begin
        got_d.push_back(m_if.tdata);
        got_l.push_back(m_if.tlast);
        got_u.push_back(m_if.tuser);
        if (first_out < 0) first_out = cyc;
        if (clr_last && got_d.size() == n) stat_clear = 1'b1;
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      pd = m_if.tdata; pl = m_if.tlast; pu = m_if.tuser;
      @(posedge ACLK); #1;
      cyc++;
    end
    stat_clear  = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    timed_out = (acc < n || got_d.size() < n) ? 1 : 0;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    checks++;
    if ({m_if.tvalid, m_if.tlast, m_if.tuser, s_if.tready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctl: got %b expected 0000", {m_if.tvalid, m_if.tlast, m_if.tuser, s_if.tready});
    end
    checks++;
    if (m_if.tdata !== 32'h0) begin
      errors++; $display("FAIL reset_tdata: got %h expected 0", m_if.tdata);
    end
    checks++;
    if ({stat_busy, stat_err_early, stat_err_late} !== 3'b000 || stat_frames !== 16'd0) begin
      errors++;
      $display("FAIL reset_stat: got %b/%0d expected 000/0", {stat_busy, stat_err_early, stat_err_late}, stat_frames);
    end
    ARESETN = 1'b1;
  endtask

  task automatic test_basic();
    cfg_width = 12'd4; cfg_height = 12'd2; cfg_enable = 1'b1;
    drive_frame(8, 32'h1, 16'h0088, 0, 0, 1'b0);
    checks++;
    if (timed_out != 0 || got_d.size() != 8) begin
      errors++; $display("FAIL basic_count: got %0d beats expected 8", got_d.size());
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= got_d.size() || got_d[i] !== 32'(i + 1) || got_l[i] !== (i % 4 == 3) || got_u[i] !== (i == 0)) begin
        errors++;
        $display("FAIL basic_beat%0d: got %h/%b/%b expected %h/%b/%b", i,
                 got_d[i], got_l[i], got_u[i], 32'(i + 1), (i % 4 == 3), (i == 0));
      end
    end
    checks++;
    if (first_out - first_in != 1) begin
      errors++; $display("FAIL basic_latency: got %0d expected 1", first_out - first_in);
    end
    checks++;
    if (stat_frames !== 16'd1 || stat_err_early !== 1'b0 || stat_err_late !== 1'b0 || stat_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_stat: got frames=%0d e=%b l=%b busy=%b expected 1/0/0/0",
               stat_frames, stat_err_early, stat_err_late, stat_busy);
    end
  endtask

  task automatic test_backpressure();
    drive_frame(8, 32'h1, 16'h0088, 1, 8, 1'b0);
    checks++;
    if (timed_out != 0 || got_d.size() != 8) begin
      errors++; $display("FAIL bp_count: got %0d beats expected 8", got_d.size());
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= got_d.size() || got_d[i] !== 32'(i + 1) || got_l[i] !== (i % 4 == 3) || got_u[i] !== (i == 0)) begin
        errors++;
        $display("FAIL bp_beat%0d: got %h/%b/%b expected %h/%b/%b", i,
                 got_d[i], got_l[i], got_u[i], 32'(i + 1), (i % 4 == 3), (i == 0));
      end
    end
    checks++;
    if (stall_viol != 0) begin
      errors++; $display("FAIL bp_stable: got %0d changes while stalled expected 0", stall_viol);
    end
    checks++;
    if (stat_frames !== 16'd2 || s_if.tready !== 1'b0) begin
      errors++; $display("FAIL bp_stat: got frames=%0d ready=%b expected 2/0", stat_frames, s_if.tready);
    end
  endtask

  task automatic test_errors();
    cfg_width = 12'd4; cfg_height = 12'd1; cfg_enable = 1'b1;
    drive_frame(4, 32'h100, 16'h0004, 0, 4, 1'b0);
    checks++;
    if (timed_out != 0 || got_d.size() != 4) begin
      errors++; $display("FAIL err_count: got %0d beats expected 4", got_d.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_l.size() || got_l[i] !== (i == 3) || got_u[i] !== (i == 0)) begin
        errors++;
        $display("FAIL err_frame%0d: got last=%b user=%b expected %b/%b", i, got_l[i], got_u[i], (i == 3), (i == 0));
      end
    end
    checks++;
    if (stat_err_early !== 1'b1 || stat_err_late !== 1'b1 || stat_frames !== 16'd3) begin
      errors++;
      $display("FAIL err_flags: got e=%b l=%b frames=%0d expected 1/1/3", stat_err_early, stat_err_late, stat_frames);
    end
  endtask

  task automatic test_clear_race();
    cfg_width = 12'd4; cfg_height = 12'd1; cfg_enable = 1'b1;
    drive_frame(4, 32'h200, 16'h0008, 0, 0, 1'b0);
    checks++;
    if (timed_out != 0 || stat_frames !== 16'd4 || stat_err_early !== 1'b1 || stat_err_late !== 1'b1) begin
      errors++;
      $display("FAIL clr_pre: got frames=%0d e=%b l=%b expected 4/1/1", stat_frames, stat_err_early, stat_err_late);
    end
    drive_frame(4, 32'h300, 16'h0008, 0, 4, 1'b1);
    checks++;
    if (timed_out != 0 || stat_frames !== 16'd1) begin
      errors++; $display("FAIL clr_frames: got %0d expected 1", stat_frames);
    end
    checks++;
    if (stat_err_early !== 1'b0 || stat_err_late !== 1'b0) begin
      errors++; $display("FAIL clr_errs: got e=%b l=%b expected 0/0", stat_err_early, stat_err_late);
    end
  endtask

  task automatic test_enable_drop();
    cfg_width = 12'd4; cfg_height = 12'd2; cfg_enable = 1'b1;
    drive_frame(8, 32'h40, 16'h0088, 0, 2, 1'b0);
    checks++;
    if (timed_out != 0 || got_d.size() != 8) begin
      errors++; $display("FAIL drop_count: got %0d beats expected 8", got_d.size());
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= got_d.size() || got_d[i] !== 32'h40 + 32'(i) || got_l[i] !== (i % 4 == 3)) begin
        errors++;
        $display("FAIL drop_beat%0d: got %h/%b expected %h/%b", i, got_d[i], got_l[i], 32'h40 + 32'(i), (i % 4 == 3));
      end
    end
    repeat (2) @(posedge ACLK);
    #1;
    checks++;
    if (s_if.tready !== 1'b0 || stat_busy !== 1'b0 || stat_frames !== 16'd2) begin
      errors++;
      $display("FAIL drop_idle: got ready=%b busy=%b frames=%0d expected 0/0/2", s_if.tready, stat_busy, stat_frames);
    end
    cfg_width = 12'd0; cfg_enable = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    checks++;
    if (s_if.tready !== 1'b0) begin
      errors++; $display("FAIL width0_idle: got ready=%b expected 0", s_if.tready);
    end
  endtask

  task automatic test_reset_midframe();
    int wait_cyc;
    cfg_width = 12'd4; cfg_height = 12'd2; cfg_enable = 1'b1;
    m_if.tready = 1'b0;
    wait_cyc = 0;
    while (s_if.tready !== 1'b1 && wait_cyc < 10) begin
      @(posedge ACLK); #1; wait_cyc++;
    end
    checks++;
    if (s_if.tready !== 1'b1) begin
      errors++; $display("FAIL mid_ready: got %b expected 1", s_if.tready);
    end
    s_if.tvalid = 1'b1; s_if.tdata = 32'h11; s_if.tlast = 1'b0;
    @(posedge ACLK); #1;
    s_if.tdata = 32'h12;
    @(posedge ACLK); #1;
    s_if.tvalid = 1'b0;
    checks++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'h11 || stat_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_stall: got v=%b d=%h busy=%b expected 1/11/1", m_if.tvalid, m_if.tdata, stat_busy);
    end
    ARESETN = 1'b0;
    @(posedge ACLK); #1;
    checks++;
    if (m_if.tvalid !== 1'b0 || m_if.tdata !== 32'h0 || s_if.tready !== 1'b0 ||
        stat_busy !== 1'b0 || stat_frames !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b d=%h r=%b busy=%b frames=%0d expected 0/0/0/0/0",
               m_if.tvalid, m_if.tdata, s_if.tready, stat_busy, stat_frames);
    end
    ARESETN = 1'b1;
    drive_frame(8, 32'h21, 16'h0088, 0, 8, 1'b0);
    checks++;
    if (timed_out != 0 || got_d.size() != 8) begin
      errors++; $display("FAIL post_count: got %0d beats expected 8", got_d.size());
    end
    checks++;
    if (got_d.size() == 0 || got_d[0] !== 32'h21 || got_u[0] !== 1'b1) begin
      errors++; $display("FAIL post_sof: got %h/%b expected 21/1", got_d[0], got_u[0]);
    end
    checks++;
    if (stat_frames !== 16'd1) begin
      errors++; $display("FAIL post_frames: got %0d expected 1", stat_frames);
    end
  endtask

  initial begin
    ARESETN = 1'b0; cfg_enable = 1'b0; cfg_width = 12'd0; cfg_height = 12'd0; stat_clear = 1'b0;
    s_if.tvalid = 1'b0; s_if.tdata = 32'h0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
    m_if.tready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_errors();
    test_clear_race();
    test_enable_drop();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_video_framer.md
Name: axis_video_framer

Overview:
- Downstream of face_swap's AXI4-Stream master output; consumes its 32-bit pixel stream and feeds the video output DMA/VDMA.
- Regenerates AXI4-Stream video framing: TUSER = start-of-frame on the first pixel, TLAST = end-of-line on the last pixel of each line. Uses line width/height latched from face_swap's AXI-Lite register file.
- Flags framing mismatches from upstream and counts completed frames.
- Full throughput (1 pixel/clk) with a registered output path.

Parameters:
- DATA_WIDTH, 32, pixel/tdata width in bits
- DIM_BITS, 12, width of line-width and line-count fields (max 4095)
- CNT_BITS, 16, width of the completed-frame counter

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  synchronous active-low reset
- cfg_enable  in  1  framer enable (from AXI-Lite reg)
- cfg_width  in  DIM_BITS  pixels per line
- cfg_height  in  DIM_BITS  lines per frame
- stat_clear  in  1  one-cycle pulse: clears sticky errors and frame counter
- s_axis_tdata  in  DATA_WIDTH  input pixel
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  upstream end-of-line marker (checked only)
- m_axis_tdata  out  DATA_WIDTH  output pixel
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  end-of-line
- m_axis_tuser  out  1  start-of-frame
- stat_busy  out  1  high while a frame is in progress
- stat_err_early  out  1  sticky: s_axis_tlast seen before the computed end-of-line
- stat_err_late  out  1  sticky: computed end-of-line reached without s_axis_tlast
- stat_frames  out  CNT_BITS  completed-frame count, wraps modulo 2^CNT_BITS

Behaviour:
- Reset (ARESETN=0 sampled at a rising ACLK edge):
  - all outputs 0, state IDLE, counters 0, skid buffer empty.
  - Reset mid-frame discards any buffered pixel, with no output handshake.
- State machine, two states:
  - IDLE: s_axis_tready=0. Go to RUN when cfg_enable=1, cfg_width!=0 and cfg_height!=0. On that transition, latch width/height into shadow registers and zero the pixel (px) and line (ln) counters.
  - RUN: accepts pixels. Return to IDLE after the handshake of the last pixel of the last line (px=w-1, ln=h-1) if cfg_enable=0, otherwise re-latch cfg and stay in RUN.
- Configuration timing:
  - Deasserting cfg_enable mid-frame does not truncate the frame; the current frame completes.
  - cfg changes mid-frame are ignored until the next frame boundary.
- Accept path: input handshake = s_axis_tvalid & s_axis_tready.
  - Per handshake, tag the pixel with tuser=(px==0 && ln==0) and tlast=(px==w-1).
  - Then increment px; on px=w-1, px wraps to 0 and ln increments; on ln=h-1 as well, ln wraps to 0.
- Error checks, per input handshake:
  - s_axis_tlast=1 with px!=w-1 sets stat_err_early.
  - s_axis_tlast=0 with px==w-1 sets stat_err_late.
  - Output framing always follows the counters, never s_axis_tlast.
- Frame counter: stat_frames increments on the output handshake (m_axis_tvalid & m_axis_tready) of a beat with tlast=1 that is the last line of the frame.
- stat_clear:
  - Zeroes stat_err_early, stat_err_late and stat_frames on the next edge.
  - If stat_clear and an error or count event occur on the same edge, the event wins: the flag is set to 1, and stat_frames is loaded with 1.
- Output path, 2-entry skid buffer:
  - Latency 1 cycle from input handshake to m_axis_tvalid.
  - s_axis_tready registered: 1 in RUN when the skid entry is empty.
  - No combinational path from m_axis_tready to s_axis_tready.
  - Sustains 1 beat/clk with m_axis_tready held high.
  - m_axis_* remain stable while m_axis_tvalid=1 and m_axis_tready=0.
- stat_busy = 1 from the first accepted pixel of a frame until the output handshake of its final beat.
- Widths: counters are DIM_BITS wide; comparisons use the latched w-1 and h-1.

Decomposition:
- Shared package face_swap_pkg: FS_DATA_WIDTH=32, FS_DIM_BITS=12, framer state enum {FR_IDLE, FR_RUN}, and the typedef for a stream beat {tdata, tlast, tuser}.
- One sub-module: axis_skid_buffer (parameterised on beat width; registered ready; 2 entries). It is reusable on face_swap's own stream port.

Test Plan:
- w=4, h=2, enable=1, continuous input 0x01..0x08 with correct s_axis_tlast, m_axis_tready=1:
  - output 0x01..0x08, tuser only on 0x01, tlast on 0x04 and 0x08;
  - stat_frames=1, no errors;
  - first output beat 1 cycle after the first input handshake.
- Same frame with m_axis_tready toggling 1,0,0,1 repeating:
  - output data and order identical, no beat lost or duplicated;
  - tdata/tlast/tuser held stable while stalled.
- w=4, h=1, s_axis_tlast on the 3rd pixel and not on the 4th:
  - stat_err_early=1 and stat_err_late=1;
  - output tlast still on the 4th beat.
- Pulse stat_clear on the same edge as the final handshake of a second frame:
  - stat_frames=1 afterwards; errors cleared (no errors in that frame).
- Drop cfg_enable after the 2nd pixel of a w=4, h=2 frame:
  - all 8 beats emitted, then IDLE and s_axis_tready=0.
  - Also: width=0 with enable=1 keeps IDLE.
- Assert ARESETN=0 for 1 cycle mid-frame with a stalled output:
  - all outputs 0 the next cycle;
  - the next frame starts with tuser=1 on its first pixel.
